// File: rtl/xbar_pkg.sv
// xbar_pkg
// Shared types and constants for the AXI4-Lite crossbar slave-side scheduler.
//   wr_state_e  : write-path ownership phases (idle, address/data, response)
//   rd_state_e  : read-path ownership phases (idle, address, response)
//   RESP_*      : AXI response codes the crossbar returns on a timeout
//   clog2_min1  : $clog2 that never yields a zero-width result
package xbar_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_XFER = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ADDR = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/xbar_rr_pick.sv
// xbar_rr_pick
// Combinational round-robin picker: selects the lowest requesting index at or
// above i_ptr, wrapping modulo N.
//   i_req   : request vector
//   i_ptr   : search start index (0..N-1)
//   o_grant : one-hot winner, zero when no request
//   o_idx   : binary index of the winner
//   o_any   : at least one request present
module xbar_rr_pick
    import xbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int   w_j;
    logic w_found;

    assign o_any = |i_req;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!w_found && i_req[w_j]) begin
                w_found      = 1'b1;
                o_grant[w_j] = 1'b1;
                o_idx        = IW'(w_j);
            end
        end
    end

endmodule

// File: rtl/xbar_slave_sched.sv
// xbar_slave_sched
// Per-slave scheduler: decides which master owns this slave's write path
// (AW/W/B) and read path (AR/R). Each path is arbitrated round-robin and held
// from the address grant until the response handshake or a response timeout.
//   aclk, aresetn        : clock, asynchronous active-low reset
//   aw_req_i / ar_req_i  : per-master address requests decoded to this slave
//   aw/w/b/ar/r_hs_i     : slave-side channel handshakes
//   w_sel_o / r_sel_o    : registered one-hot owner, zero when free
//   w_busy_o / r_busy_o  : registered |sel
//   w/r_timeout_o        : one-cycle pulse after a timeout release
module xbar_slave_sched
    import xbar_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [N_MASTERS-1:0] aw_req_i,
    input  logic [N_MASTERS-1:0] ar_req_i,
    input  logic                 aw_hs_i,
    input  logic                 w_hs_i,
    input  logic                 b_hs_i,
    input  logic                 ar_hs_i,
    input  logic                 r_hs_i,
    output logic [N_MASTERS-1:0] w_sel_o,
    output logic [N_MASTERS-1:0] r_sel_o,
    output logic                 w_busy_o,
    output logic                 r_busy_o,
    output logic                 w_timeout_o,
    output logic                 r_timeout_o
);

    localparam int  IW    = clog2_min1(N_MASTERS);
    localparam int  TO_W  = clog2_min1(TIMEOUT_CYCLES + 1);
    localparam bit  TO_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0] CNT_MAX = '1;

    function automatic logic [IW-1:0] ptr_after(input logic [IW-1:0] idx);
        if (int'(idx) == N_MASTERS - 1) return '0;
        return idx + 1'b1;
    endfunction

    // write path state
    wr_state_e            r_wstate, w_wstate_nxt;
    logic [N_MASTERS-1:0] r_wsel, w_wsel_nxt;
    logic [IW-1:0]        r_widx, w_widx_nxt;
    logic [IW-1:0]        r_wptr, w_wptr_nxt;
    logic [TO_W-1:0]      r_wcnt, w_wcnt_nxt;
    logic                 r_aw_done, w_aw_done_nxt;
    logic                 r_w_done, w_w_done_nxt;
    logic                 r_wbusy, r_wto, w_wto_nxt, w_wrel;

    // read path state
    rd_state_e            r_rstate, w_rstate_nxt;
    logic [N_MASTERS-1:0] r_rsel, w_rsel_nxt;
    logic [IW-1:0]        r_ridx, w_ridx_nxt;
    logic [IW-1:0]        r_rptr, w_rptr_nxt;
    logic [TO_W-1:0]      r_rcnt, w_rcnt_nxt;
    logic                 r_rbusy, r_rto, w_rto_nxt, w_rrel;

    logic [N_MASTERS-1:0] w_wgrant, w_rgrant;
    logic [IW-1:0]        w_widx_pick, w_ridx_pick;
    logic                 w_wany, w_rany;

    xbar_rr_pick #(.N(N_MASTERS), .IW(IW)) u_wpick (
        .i_req   (aw_req_i),
        .i_ptr   (r_wptr),
        .o_grant (w_wgrant),
        .o_idx   (w_widx_pick),
        .o_any   (w_wany)
    );

    xbar_rr_pick #(.N(N_MASTERS), .IW(IW)) u_rpick (
        .i_req   (ar_req_i),
        .i_ptr   (r_rptr),
        .o_grant (w_rgrant),
        .o_idx   (w_ridx_pick),
        .o_any   (w_rany)
    );

    // Write FSM: AW and W may complete in either order or together; the
    // response wait starts only once both have been seen.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_wsel_nxt    = r_wsel;
        w_widx_nxt    = r_widx;
        w_wptr_nxt    = r_wptr;
        w_wcnt_nxt    = r_wcnt;
        w_aw_done_nxt = r_aw_done;
        w_w_done_nxt  = r_w_done;
        w_wto_nxt     = 1'b0;
        w_wrel        = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (w_wany) begin
                    w_wstate_nxt  = W_XFER;
                    w_wsel_nxt    = w_wgrant;
                    w_widx_nxt    = w_widx_pick;
                    w_aw_done_nxt = 1'b0;
                    w_w_done_nxt  = 1'b0;
                end
            end
            W_XFER: begin
                w_aw_done_nxt = r_aw_done | aw_hs_i;
                w_w_done_nxt  = r_w_done | w_hs_i;
                if (w_aw_done_nxt && w_w_done_nxt) begin
                    w_wstate_nxt = W_RESP;
                    w_wcnt_nxt   = '0;
                end
            end
            W_RESP: begin
                // a response arriving on the last allowed cycle beats the timeout
                if (b_hs_i) begin
                    w_wrel = 1'b1;
                end else if (TO_EN && (r_wcnt == TO_LAST)) begin
                    w_wrel    = 1'b1;
                    w_wto_nxt = 1'b1;
                end else if (r_wcnt != CNT_MAX) begin
                    w_wcnt_nxt = r_wcnt + 1'b1;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
        if (w_wrel) begin
            w_wstate_nxt = W_IDLE;
            w_wsel_nxt   = '0;
            w_wptr_nxt   = ptr_after(r_widx);
        end
    end

    // Read FSM
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_rsel_nxt   = r_rsel;
        w_ridx_nxt   = r_ridx;
        w_rptr_nxt   = r_rptr;
        w_rcnt_nxt   = r_rcnt;
        w_rto_nxt    = 1'b0;
        w_rrel       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (w_rany) begin
                    w_rstate_nxt = R_ADDR;
                    w_rsel_nxt   = w_rgrant;
                    w_ridx_nxt   = w_ridx_pick;
                end
            end
            R_ADDR: begin
                if (ar_hs_i) begin
                    w_rstate_nxt = R_RESP;
                    w_rcnt_nxt   = '0;
                end
            end
            R_RESP: begin
                if (r_hs_i) begin
                    w_rrel = 1'b1;
                end else if (TO_EN && (r_rcnt == TO_LAST)) begin
                    w_rrel    = 1'b1;
                    w_rto_nxt = 1'b1;
                end else if (r_rcnt != CNT_MAX) begin
                    w_rcnt_nxt = r_rcnt + 1'b1;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
        if (w_rrel) begin
            w_rstate_nxt = R_IDLE;
            w_rsel_nxt   = '0;
            w_rptr_nxt   = ptr_after(r_ridx);
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate  <= W_IDLE;
            r_wsel    <= '0;
            r_widx    <= '0;
            r_wptr    <= '0;
            r_wcnt    <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wbusy   <= 1'b0;
            r_wto     <= 1'b0;
            r_rstate  <= R_IDLE;
            r_rsel    <= '0;
            r_ridx    <= '0;
            r_rptr    <= '0;
            r_rcnt    <= '0;
            r_rbusy   <= 1'b0;
            r_rto     <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_wsel    <= w_wsel_nxt;
            r_widx    <= w_widx_nxt;
            r_wptr    <= w_wptr_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_aw_done <= w_aw_done_nxt;
            r_w_done  <= w_w_done_nxt;
            r_wbusy   <= |w_wsel_nxt;
            r_wto     <= w_wto_nxt;
            r_rstate  <= w_rstate_nxt;
            r_rsel    <= w_rsel_nxt;
            r_ridx    <= w_ridx_nxt;
            r_rptr    <= w_rptr_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rbusy   <= |w_rsel_nxt;
            r_rto     <= w_rto_nxt;
        end
    end

    assign w_sel_o     = r_wsel;
    assign r_sel_o     = r_rsel;
    assign w_busy_o    = r_wbusy;
    assign r_busy_o    = r_rbusy;
    assign w_timeout_o = r_wto;
    assign r_timeout_o = r_rto;

endmodule

// File: tb/tb_xbar_slave_sched.sv
// tb_xbar_slave_sched
// Directed scenarios followed by random traffic, every cycle compared against a
// transaction-level ownership model of the write and read paths.
module tb_xbar_slave_sched;

    localparam int N = 3;
    localparam int T = 4;

    logic         aclk;
    logic         aresetn;
    logic [N-1:0] aw_req_i, ar_req_i;
    logic         aw_hs_i, w_hs_i, b_hs_i, ar_hs_i, r_hs_i;
    logic [N-1:0] w_sel_o, r_sel_o;
    logic         w_busy_o, r_busy_o, w_timeout_o, r_timeout_o;

    int total = 0;
    int bad   = 0;

    // model: owner index (-1 = free), phase 0 idle / 1 transfer / 2 response
    int m_wown, m_wptr, m_wph, m_wwait;
    bit m_aw, m_w, m_wto;
    int m_rown, m_rptr, m_rph, m_rwait;
    bit m_rto;

    xbar_slave_sched #(.N_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .aw_req_i    (aw_req_i),
        .ar_req_i    (ar_req_i),
        .aw_hs_i     (aw_hs_i),
        .w_hs_i      (w_hs_i),
        .b_hs_i      (b_hs_i),
        .ar_hs_i     (ar_hs_i),
        .r_hs_i      (r_hs_i),
        .w_sel_o     (w_sel_o),
        .r_sel_o     (r_sel_o),
        .w_busy_o    (w_busy_o),
        .r_busy_o    (r_busy_o),
        .w_timeout_o (w_timeout_o),
        .r_timeout_o (r_timeout_o)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int own);
        logic [N-1:0] v;
        v = '0;
        if (own >= 0) v[own] = 1'b1;
        return v;
    endfunction

    function automatic int pick(input logic [N-1:0] req, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (req[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_wown = -1; m_wptr = 0; m_wph = 0; m_wwait = 0; m_aw = 0; m_w = 0; m_wto = 0;
        m_rown = -1; m_rptr = 0; m_rph = 0; m_rwait = 0; m_rto = 0;
    endtask

    // one clock edge worth of the ownership rules, using the inputs held across it
    task automatic model_step();
        int j;
        bit rel;
        m_wto = 0;
        rel   = 0;
        if (m_wph == 0) begin
            j = pick(aw_req_i, m_wptr);
            if (j >= 0) begin m_wown = j; m_wph = 1; m_aw = 0; m_w = 0; end
        end else if (m_wph == 1) begin
            if (aw_hs_i) m_aw = 1;
            if (w_hs_i)  m_w  = 1;
            if (m_aw && m_w) begin m_wph = 2; m_wwait = 0; end
        end else begin
            if (b_hs_i) rel = 1;
            else if (m_wwait + 1 == T) begin rel = 1; m_wto = 1; end
            else m_wwait++;
        end
        if (rel) begin m_wptr = (m_wown + 1) % N; m_wown = -1; m_wph = 0; end

        m_rto = 0;
        rel   = 0;
        if (m_rph == 0) begin
            j = pick(ar_req_i, m_rptr);
            if (j >= 0) begin m_rown = j; m_rph = 1; end
        end else if (m_rph == 1) begin
            if (ar_hs_i) begin m_rph = 2; m_rwait = 0; end
        end else begin
            if (r_hs_i) rel = 1;
            else if (m_rwait + 1 == T) begin rel = 1; m_rto = 1; end
            else m_rwait++;
        end
        if (rel) begin m_rptr = (m_rown + 1) % N; m_rown = -1; m_rph = 0; end
    endtask

    task automatic check_all();
        chk("w_sel",     w_sel_o,     onehot(m_wown));
        chk("w_busy",    w_busy_o,    m_wown >= 0);
        chk("w_timeout", w_timeout_o, m_wto);
        chk("r_sel",     r_sel_o,     onehot(m_rown));
        chk("r_busy",    r_busy_o,    m_rown >= 0);
        chk("r_timeout", r_timeout_o, m_rto);
    endtask

    task automatic cyc();
        @(posedge aclk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic hs_clear();
        aw_hs_i = 0; w_hs_i = 0; b_hs_i = 0; ar_hs_i = 0; r_hs_i = 0;
    endtask

    initial begin
        aresetn  = 1'b0;
        aw_req_i = '0;
        ar_req_i = '0;
        hs_clear();
        model_reset();
        repeat (2) @(posedge aclk);
        #1;
        check_all();

        // both masters request at reset exit: master 0 first, then master 1
        aw_req_i = 3'b011;
        aresetn  = 1'b1;
        cyc(); chk("rr_first", w_sel_o, 3'b001);
        aw_hs_i = 1; cyc();
        aw_hs_i = 0; w_hs_i = 1; cyc();
        w_hs_i = 0; b_hs_i = 1; cyc(); chk("gap_after_b", w_sel_o, 3'b000);
        b_hs_i = 0; cyc(); chk("rr_second", w_sel_o, 3'b010);

        // aw and w together, b three cycles on; sel held through the b cycle
        aw_hs_i = 1; w_hs_i = 1; cyc();
        hs_clear(); cyc(); cyc();
        b_hs_i = 1; chk("held_in_b", w_sel_o, 3'b010);
        cyc(); chk("drop_after_b", w_sel_o, 3'b000);

        // ptr is 2, requests 011 -> wrap to master 0, then ptr becomes 1
        b_hs_i = 0; cyc(); chk("wrap_grant", w_sel_o, 3'b001);
        aw_hs_i = 1; w_hs_i = 1; cyc();
        hs_clear(); b_hs_i = 1; cyc();
        b_hs_i = 0; cyc(); chk("ptr_after_wrap", w_sel_o, 3'b010);

        // reset while in response wait
        aw_hs_i = 1; w_hs_i = 1; cyc();
        hs_clear(); cyc();
        aresetn = 1'b0;
        #1;
        model_reset();
        chk("rst_w_sel", w_sel_o, 3'b000);
        chk("rst_w_busy", w_busy_o, 1'b0);
        @(posedge aclk); #1; check_all();
        aresetn  = 1'b1;
        aw_req_i = 3'b110;
        ar_req_i = 3'b001;
        cyc();
        chk("post_rst_w", w_sel_o, 3'b010);
        chk("post_rst_r", r_sel_o, 3'b001);

        // read completes while write is held
        ar_req_i = '0; ar_hs_i = 1; cyc();
        ar_hs_i = 0; r_hs_i = 1; cyc();
        chk("r_done_w_held", w_sel_o, 3'b010);
        chk("r_done_free", r_sel_o, 3'b000);

        // read timeout: no r_hs for four response cycles
        r_hs_i = 0; ar_req_i = 3'b100; cyc(); chk("r_grant2", r_sel_o, 3'b100);
        ar_req_i = '0; ar_hs_i = 1; cyc();
        ar_hs_i = 0; cyc(); cyc(); cyc();
        chk("r_held_3", r_sel_o, 3'b100);
        cyc();
        chk("to_sel", r_sel_o, 3'b000);
        chk("to_pulse", r_timeout_o, 1'b1);
        cyc();
        chk("to_one_cycle", r_timeout_o, 1'b0);

        // r_hs on the fourth response cycle beats the timeout
        ar_req_i = 3'b001; cyc(); chk("r_grant0", r_sel_o, 3'b001);
        ar_req_i = '0; ar_hs_i = 1; cyc();
        ar_hs_i = 0; cyc(); cyc(); cyc();
        r_hs_i = 1; cyc();
        chk("hs_wins_sel", r_sel_o, 3'b000);
        chk("hs_wins_pulse", r_timeout_o, 1'b0);
        r_hs_i = 0; cyc();
        chk("hs_wins_after", r_timeout_o, 1'b0);

        // random traffic, including out-of-place handshakes and one reset
        for (int i = 0; i < 800; i++) begin
            aw_req_i = N'($urandom_range(0, 7));
            ar_req_i = N'($urandom_range(0, 7));
            aw_hs_i  = ($urandom_range(0, 2) == 0);
            w_hs_i   = ($urandom_range(0, 2) == 0);
            ar_hs_i  = ($urandom_range(0, 2) == 0);
            b_hs_i   = ($urandom_range(0, 5) == 0);
            r_hs_i   = ($urandom_range(0, 5) == 0);
            if (i == 400) begin
                aresetn = 1'b0;
                #1;
                model_reset();
                check_all();
                @(posedge aclk); #1; check_all();
                aresetn = 1'b1;
            end
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
